clock_sequencer: RTL
====================

Name: clock_sequencer

Overview:
- Parametrised CPU clock source: derives a slow processor clock `clk` and NUM_PH one-cycle phase strobes `pclk` from the board clock `raw_clk`.
- Modes: free-running auto, debounced manual (push-button), single-step and halt.
- Divider is runtime-programmable.
- Sits between board clock/buttons and the CPU core; all CPU stage logic keys off `pclk` strobes.

Parameters:
- CNT_W, 32, width of slot-length counter and divider register.
- DIV_DEFAULT, 32'h003CFC20, slot length (raw_clk cycles per phase) loaded at reset.
- NUM_PH, 4, phases per clk period; power of 2, >=2.
- DB_CYCLES, 16'd50000, raw_clk cycles manual_clk must be stable to be accepted.

Ports:
- raw_clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- mode, in, 2, 00 auto, 01 manual, 10 step, 11 halt.
- manual_clk, in, 1, asynchronous button level.
- step_req, in, 1, asynchronous step button; rising edge requests one period.
- div_load, in, 1, load div_val.
- div_val, in, CNT_W, new slot length.
- clk, out, 1, processor clock.
- pclk, out, NUM_PH, phase strobes.
- tick, out, 1, one-cycle strobe coincident with each clk rise.
- busy, out, 1, high while a period is in progress (RUN state).

Behaviour:
- One clock, raw_clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - Outputs: clk=0, pclk=0, tick=0, busy=0.
  - FSM=IDLE; phase p=0; slot count s=0; div=DIV_DEFAULT.
  - Synchronisers and debounce state cleared.
- Input conditioning:
  - manual_clk and step_req each pass through a 2-flop synchroniser.
  - manual_clk is then debounced: a new level is accepted only after DB_CYCLES consecutive identical synchronised samples.
  - Debounce counter restarts on any change.
- Divider:
  - div_load captures div_val into pending register; div_val=0 is stored as 1.
  - Pending value applies only when p wraps NUM_PH-1 -> 0, never mid-period.
  - A load during IDLE applies immediately.
- RUN counting:
  - s counts 0..div-1.
  - At s==div-1: s<=0, p<=p+1 mod NUM_PH.
  - Period = NUM_PH*div raw_clk cycles.
- clk = (p >= NUM_PH/2) while in RUN: low for the first half of the period, high for the second half.
- pclk[k] is high exactly in cycles where state is RUN and (p,s)==(k,0). It is registered from next-state decode, so it is glitch-free.
- tick is high in the cycle where (p,s)==(NUM_PH/2,0).
- FSM states: IDLE, RUN, MANUAL, HALT. Transitions are evaluated every raw_clk edge.
  - IDLE (clk=0, counters 0):
    - mode=auto: -> RUN at (0,0) next cycle.
    - mode=step with synchronised step_req rising edge: -> RUN.
    - mode=manual: -> MANUAL.
  - RUN:
    - After the last cycle of slot NUM_PH-1, if mode!=auto: -> IDLE. Step therefore yields exactly one full period.
    - mode=halt: -> HALT immediately, freezing p, s, clk; pclk=0.
    - mode=manual: -> MANUAL immediately.
  - HALT:
    - Leaving halt to auto/step resumes RUN from the frozen (p,s).
    - No pclk[k] re-strobe unless s==0 was the frozen point.
    - Leaving halt to manual: -> MANUAL.
  - MANUAL:
    - clk = debounced manual_clk; pclk=0; tick on debounced rising edge.
    - When mode!=manual: -> IDLE (clk<=0, counters 0).
- Step edge cases:
  - step_req edges while in RUN, HALT or MANUAL are ignored, not queued.
  - Simultaneous step edge and mode change out of step: mode wins.
- Reset mid-period: immediate return to IDLE; the partial period is discarded.
- busy = (state==RUN).

Optional Feature:
- Macro: CLKSEQ_STALL_EN.
- With macro:
  - Adds input port `stall` (1 bit).
  - If stall is high in RUN at (p,s)==(NUM_PH-1,div-1), state holds there (clk stays high, no wrap, busy stays 1) until stall falls; wrap occurs on the first edge with stall low.
  - stall is ignored at all other points.
  - This gives wait-states for slow memory.
- Without macro: no port; periods are never extended.

Test Plan:
- Auto, NUM_PH=4, div_load with div_val=3 in IDLE, mode=00 -> period 12 cycles; clk low 6/high 6; pclk[0..3] at offsets 0,3,6,9 after RUN entry; tick at offset 6; repeats.
- div_load div_val=5 at offset 4 of a period (div=3) -> current period unchanged (12 cycles); next period 20 cycles; div_val=0 -> slot length 1.
- Step mode, two step_req pulses 3 cycles apart, second mid-period -> exactly one 12-cycle period, then IDLE, clk=0, busy=0; second request ignored.
- Manual, DB_CYCLES=4: manual_clk bounces 1-0-1 at 1-cycle spacing then holds 1 -> clk rises exactly 4 cycles after last change + 2 sync cycles; tick pulses once; pclk stays 0.
- Auto running, mode=halt at (2,1) for 10 cycles, then auto -> clk frozen high, no pclk; resumes at (2,1), remaining period 6 cycles; rst_n low mid-period -> all outputs 0 asynchronously.
- CLKSEQ_STALL_EN build, stall high 7 cycles at end of slot 3 -> period 19 cycles; clk high throughout the stall; pclk[0] at cycle 19.

Source files
------------

// File: rtl/clock_sequencer.sv
// clock_sequencer
//   Derives the slow CPU clock `clk` and NUM_PH one-cycle phase strobes `pclk`
//   from the board clock `raw_clk`. The sequencer runs free (auto), follows a
//   debounced push-button (manual), runs exactly one period per button press
//   (step) or freezes mid-period (halt). The slot length is programmable at
//   runtime and only changes on a period boundary.
//
//   Optional build macro: CLKSEQ_STALL_EN adds a `stall` input that holds the
//   sequencer on the last cycle of the last slot (wait-states).
//
// Ports
//   raw_clk    in   sole clock
//   rst_n      in   asynchronous active-low reset
//   mode       in   00 auto, 01 manual, 10 step, 11 halt
//   manual_clk in   asynchronous button level (synchronised + debounced)
//   step_req   in   asynchronous step button, rising edge requests one period
//   div_load   in   capture div_val as the pending slot length
//   div_val    in   new slot length (0 is treated as 1)
//   stall      in   (CLKSEQ_STALL_EN only) extend the period at its last cycle
//   clk        out  processor clock
//   pclk       out  phase strobes, pclk[k] high on the first cycle of slot k
//   tick       out  strobe coincident with each clk rise
//   busy       out  high while a period is in progress
module clock_sequencer #(
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DIV_DEFAULT = 'h003C_FC20,
    parameter int               NUM_PH      = 4,
    parameter logic [15:0]      DB_CYCLES   = 16'd50000
) (
    input  logic              raw_clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              manual_clk,
    input  logic              step_req,
    input  logic              div_load,
    input  logic [CNT_W-1:0]  div_val,
`ifdef CLKSEQ_STALL_EN
    input  logic              stall,
`endif
    output logic              clk,
    output logic [NUM_PH-1:0] pclk,
    output logic              tick,
    output logic              busy
);

    localparam int             PW     = $clog2(NUM_PH);
    localparam logic [PW-1:0]  P_LAST = PW'(NUM_PH - 1);
    localparam logic [PW-1:0]  P_HALF = PW'(NUM_PH / 2);

    localparam logic [1:0] M_AUTO   = 2'b00;
    localparam logic [1:0] M_MANUAL = 2'b01;
    localparam logic [1:0] M_STEP   = 2'b10;
    localparam logic [1:0] M_HALT   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_MANUAL, S_HALT} state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      p_q, p_d;
    logic [CNT_W-1:0]   s_q, s_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic               ms1_q, ms1_d, ms2_q, ms2_d;
    logic               deb_q, deb_d;
    logic [15:0]        db_cnt_q, db_cnt_d;
    logic               ss1_q, ss1_d, ss2_q, ss2_d, ss3_q, ss3_d;
    logic               clk_q, clk_d;
    logic [NUM_PH-1:0]  pclk_q, pclk_d;
    logic               tick_q, tick_d;
    logic               busy_q, busy_d;

    logic               step_rise;
    logic [CNT_W-1:0]   div_in, pend_val;
    logic               pend_has, apply_div;
    logic               slot_end, wrap, stall_hold, run_n;

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        s_d        = s_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        apply_div  = 1'b0;

        // Two-flop synchronisers; a third step flop gives the edge detect.
        ms1_d = manual_clk;
        ms2_d = ms1_q;
        ss1_d = step_req;
        ss2_d = ss1_q;
        ss3_d = ss2_q;
        step_rise = ss2_q & ~ss3_q;

        // Debounce: count consecutive samples that differ from the accepted
        // level; any sample matching the accepted level restarts the count.
        deb_d    = deb_q;
        db_cnt_d = db_cnt_q;
        if (ms2_q == deb_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_CYCLES - 16'd1) begin
            deb_d    = ms2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 16'd1;
        end

        // Pending divider; a load in the same cycle as a boundary is taken.
        div_in   = (div_val == '0) ? CNT_W'(1) : div_val;
        pend_val = div_load ? div_in : pend_q;
        pend_has = div_load | pend_vld_q;
        if (div_load) begin
            pend_d     = div_in;
            pend_vld_d = 1'b1;
        end

        slot_end = (s_q == div_q - CNT_W'(1));
        wrap     = slot_end && (p_q == P_LAST);
`ifdef CLKSEQ_STALL_EN
        stall_hold = stall && wrap;
`else
        stall_hold = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                p_d       = '0;
                s_d       = '0;
                apply_div = 1'b1;
                unique case (mode)
                    M_AUTO:   state_d = S_RUN;
                    M_STEP:   if (step_rise) state_d = S_RUN;
                    M_MANUAL: state_d = S_MANUAL;
                    default:  state_d = S_IDLE;
                endcase
            end
            S_RUN: begin
                if (mode == M_HALT) begin
                    state_d = S_HALT;
                end else if (mode == M_MANUAL) begin
                    state_d = S_MANUAL;
                    p_d     = '0;
                    s_d     = '0;
                end else if (stall_hold) begin
                    state_d = S_RUN;
                end else if (slot_end) begin
                    s_d = '0;
                    if (p_q == P_LAST) begin
                        p_d       = '0;
                        apply_div = 1'b1;
                        if (mode != M_AUTO) state_d = S_IDLE;
                    end else begin
                        p_d = p_q + PW'(1);
                    end
                end else begin
                    s_d = s_q + CNT_W'(1);
                end
            end
            S_HALT: begin
                unique case (mode)
                    M_AUTO, M_STEP: state_d = S_RUN;
                    M_MANUAL: begin
                        state_d = S_MANUAL;
                        p_d     = '0;
                        s_d     = '0;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            default: begin // S_MANUAL
                p_d = '0;
                s_d = '0;
                if (mode != M_MANUAL) state_d = S_IDLE;
            end
        endcase

        if (apply_div && pend_has) begin
            div_d      = pend_val;
            pend_vld_d = 1'b0;
        end

        // Outputs decoded from the next state so they register glitch-free
        // and line up with the state they describe.
        run_n  = (state_d == S_RUN);
        busy_d = run_n;
        if (state_d == S_MANUAL) begin
            clk_d = deb_d;
        end else begin
            clk_d = (run_n || state_d == S_HALT) && (p_d >= P_HALF);
        end
        for (int k = 0; k < NUM_PH; k++) begin
            pclk_d[k] = run_n && (p_d == PW'(k)) && (s_d == '0);
        end
        tick_d = (run_n && (p_d == P_HALF) && (s_d == '0)) ||
                 ((state_d == S_MANUAL) && deb_d && !deb_q);
    end

    always_ff @(posedge raw_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            p_q        <= '0;
            s_q        <= '0;
            div_q      <= DIV_DEFAULT;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ms1_q      <= 1'b0;
            ms2_q      <= 1'b0;
            deb_q      <= 1'b0;
            db_cnt_q   <= '0;
            ss1_q      <= 1'b0;
            ss2_q      <= 1'b0;
            ss3_q      <= 1'b0;
            clk_q      <= 1'b0;
            pclk_q     <= '0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            s_q        <= s_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ms1_q      <= ms1_d;
            ms2_q      <= ms2_d;
            deb_q      <= deb_d;
            db_cnt_q   <= db_cnt_d;
            ss1_q      <= ss1_d;
            ss2_q      <= ss2_d;
            ss3_q      <= ss3_d;
            clk_q      <= clk_d;
            pclk_q     <= pclk_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
        end
    end

    assign clk  = clk_q;
    assign pclk = pclk_q;
    assign tick = tick_q;
    assign busy = busy_q;

endmodule
